rs_kes_sched: RTL and testbench
===============================

Name: rs_kes_sched

Overview:
- Controller that sequences the shared key-equation-solver (KES, Euclid, t=2, GF(2^8)) stage of the RS decoder.
- Accepts one syndrome set per block from the syndrome stage over a valid/ready handshake.
- All-zero syndromes bypass the KES. Otherwise it launches the KES with a one-cycle kes_ena, holds its syndrome inputs stable and captures lambda/omega on kes_done.
- Forwards results with the block tag to the Chien/Forney stage. A watchdog flags a KES that never completes.

Parameters:
- TAG_W, 4, width of block tag carried alongside syndromes/results.
- TMO_CYC, 8, maximum cycles spent in WAIT before a timeout fail is declared (legal range 2..255).
- CNT_W, 16, width of statistics counters (optional feature only).

Ports:
- clk  in  1  clock.
- rstn  in  1  reset.
- in_valid  in  1  syndrome set valid.
- in_ready  out  1  scheduler can accept a set.
- in_syn  in  32  {syn3,syn2,syn1,syn0}, 8 bits each.
- in_tag  in  TAG_W  block tag.
- kes_ena  out  1  one-cycle KES launch strobe.
- kes_syn0..kes_syn3  out  8 each  syndromes driven to the KES.
- kes_done  in  1  KES completion pulse.
- kes_lambda0..kes_lambda2  in  8 each  KES error-locator coefficients.
- kes_omega0, kes_omega1  in  8 each  KES error-evaluator coefficients.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_lambda  out  24  {lambda2,lambda1,lambda0}.
- out_omega  out  16  {omega1,omega0}.
- out_tag  out  TAG_W  tag of the result.
- out_no_err  out  1  result came from the zero-syndrome bypass.
- out_fail  out  1  result came from a watchdog timeout.
- err_sticky  out  1  set on any timeout; cleared only by reset.

Behaviour:
- Reset: rstn is asynchronous, active-low; clock is clk. All registered outputs reset to 0. State resets to IDLE, so in_ready=1 in the first cycle after reset release.
- States: IDLE, LAUNCH, WAIT, OUT (2-bit encoding from the package).
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, register in_syn and in_tag.
  - If in_syn==0: go to OUT with out_lambda=24'h000001, out_omega=0, out_no_err=1. out_valid asserts the next cycle.
  - Otherwise go to LAUNCH.
- LAUNCH:
  - kes_ena=1 for exactly this cycle.
  - kes_syn0..3 are driven from the registered syndromes. They stay stable from LAUNCH until the scheduler leaves WAIT and are otherwise held at their last value.
  - Next state is WAIT; the timer is cleared to 0.
- WAIT:
  - Timer increments each cycle.
  - If kes_done=1: capture kes_lambda*/kes_omega* in that same cycle, set no_err=0 and fail=0, go to OUT.
  - Else if timer==TMO_CYC-1: go to OUT with lambda=0, omega=0, out_fail=1, and set err_sticky.
  - kes_done and timeout in the same cycle: kes_done wins.
- OUT:
  - out_valid=1. All out_* fields stay stable until out_ready.
  - On out_valid&out_ready go to IDLE.
  - in_ready=0 in OUT, LAUNCH and WAIT; no overlap of blocks.
- Ignored events: kes_done outside WAIT is ignored. in_valid outside IDLE is not accepted.
- Latency:
  - Bypass: out_valid appears 1 cycle after acceptance.
  - KES path: out_valid appears 1 cycle after the kes_done cycle.
  - Minimum KES-path round trip is 4 cycles (accept → LAUNCH → WAIT(≥1) → OUT).
- Reset mid-operation: the state returns to IDLE immediately, without completing or flushing the pending result.
- After a timeout the KES may remain busy, so later launches are not guaranteed to complete. err_sticky signals system-level recovery.

Optional Feature:
- Macro: KES_SCHED_STATS_EN.
- When defined, add three output ports, CNT_W each:
  - stat_blocks: increments on every out handshake.
  - stat_bypass: increments on out handshakes with out_no_err=1.
  - stat_fail: increments on out handshakes with out_fail=1.
- All three reset to 0 and saturate at all-ones.
- When not defined, these ports and their logic are absent and the behaviour is otherwise identical.

Decomposition:
- Package rs_dec_pkg holds:
  - GF_W=8, T=2, NSYN=4.
  - The scheduler state encoding (IDLE=0, LAUNCH=1, WAIT=2, OUT=3).
  - Bypass constant LAMBDA_NOERR=24'h000001.
- One sub-module, rs_kes_sched_stats: the saturating counter bank, instantiated only under KES_SCHED_STATS_EN. The FSM and watchdog stay in the top.

Test Plan:
- Zero-syndrome bypass: in_syn=0, tag=3 → kes_ena never asserts; out_valid 1 cycle later; lambda=24'h000001, omega=0, no_err=1, tag=3.
- Normal solve: in_syn=32'h0A_1F_33_C4 → kes_ena single pulse; kes_syn0..3 stable through WAIT. Model kes_done 3 cycles after launch with lambda=24'h00_5A_01, omega=16'h00_77 → out carries exactly those values, no_err=0, fail=0.
- Timeout: KES model never returns kes_done, TMO_CYC=8 → out_fail=1 after 8 WAIT cycles, lambda/omega=0, err_sticky=1 until reset.
- Backpressure: out_ready low for 5 cycles with a result pending → out_* stable, in_ready=0, a second in_valid is not accepted. Once out_ready=1 the next block is accepted in IDLE.
- Spurious and simultaneous events: kes_done pulsed in IDLE is ignored. kes_done coinciding with the final timeout cycle → result captured, fail=0.
- Reset mid-WAIT: rstn low → outputs 0, state IDLE, in_ready=1 after release. With KES_SCHED_STATS_EN, counters read 0.

Source files
------------

// File: rtl/rs_kes_sched_pkg.sv
// Shared RS decoder constants: field/syndrome sizing, KES scheduler state encoding, bypass result.
// Pure declarations, no logic; imported by the scheduler slice.
package rs_dec_pkg;
  localparam int GF_W = 8;
  localparam int T    = 2;
  localparam int NSYN = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_OUT    = 2'd3
  } sched_state_e;

  // Error locator of a clean codeword is the constant polynomial 1.
  localparam logic [(T+1)*GF_W-1:0] LAMBDA_NOERR = 24'h000001;

  typedef struct packed {
    logic [(T+1)*GF_W-1:0] lambda;
    logic [T*GF_W-1:0]     omega;
    logic                  no_err;
    logic                  fail;
  } kes_res_t;
endpackage

// File: rtl/rs_kes_sched_if.sv
// Syndrome-in / result-out valid-ready bundle around the KES scheduler.
// slave = scheduler side, master = syndrome producer plus Chien/Forney consumer.
interface rs_kes_sched_if #(parameter int TAG_W = 4);
  import rs_dec_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic [NSYN*GF_W-1:0]    in_syn;
  logic [TAG_W-1:0]        in_tag;
  logic                    out_valid;
  logic                    out_ready;
  logic [(T+1)*GF_W-1:0]   out_lambda;
  logic [T*GF_W-1:0]       out_omega;
  logic [TAG_W-1:0]        out_tag;
  logic                    out_no_err;
  logic                    out_fail;

  modport master (
    output in_valid, in_syn, in_tag, out_ready,
    input  in_ready, out_valid, out_lambda, out_omega, out_tag, out_no_err, out_fail
  );
  modport slave (
    input  in_valid, in_syn, in_tag, out_ready,
    output in_ready, out_valid, out_lambda, out_omega, out_tag, out_no_err, out_fail
  );
endinterface

// File: rtl/rs_kes_sched_stats.sv
// Saturating block/bypass/fail counters, stepped on each result handshake; 1-cycle update latency.
// Passive observer: never backpressures.
module rs_kes_sched_stats #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             hs,
  input  logic             no_err,
  input  logic             fail,
  output logic [CNT_W-1:0] stat_blocks,
  output logic [CNT_W-1:0] stat_bypass,
  output logic [CNT_W-1:0] stat_fail
);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_blocks <= '0;
      stat_bypass <= '0;
      stat_fail   <= '0;
    end else if (hs) begin
      if (stat_blocks != '1)           stat_blocks <= stat_blocks + 1'b1;
      if (no_err && stat_bypass != '1) stat_bypass <= stat_bypass + 1'b1;
      if (fail && stat_fail != '1)     stat_fail   <= stat_fail + 1'b1;
    end
  end
endmodule

// File: rtl/rs_kes_sched.sv
// KES scheduler: zero-syndrome bypass (result 1 cycle after accept) or launch/wait/capture (result 1 cycle after kes_done), with watchdog.
// One block in flight; in_ready drops until the result is taken. KES_SCHED_STATS_EN adds stat_* counters.
module rs_kes_sched
  import rs_dec_pkg::*;
#(
  parameter int TAG_W   = 4,
  parameter int TMO_CYC = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rstn,
  rs_kes_sched_if.slave    bus,
  output logic             kes_ena,
  output logic [GF_W-1:0]  kes_syn0,
  output logic [GF_W-1:0]  kes_syn1,
  output logic [GF_W-1:0]  kes_syn2,
  output logic [GF_W-1:0]  kes_syn3,
  input  logic             kes_done,
  input  logic [GF_W-1:0]  kes_lambda0,
  input  logic [GF_W-1:0]  kes_lambda1,
  input  logic [GF_W-1:0]  kes_lambda2,
  input  logic [GF_W-1:0]  kes_omega0,
  input  logic [GF_W-1:0]  kes_omega1,
  output logic             err_sticky
`ifdef KES_SCHED_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_blocks,
  output logic [CNT_W-1:0] stat_bypass,
  output logic [CNT_W-1:0] stat_fail
`endif
);
  localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

  sched_state_e         state_q, state_d;
  kes_res_t             res_q, res_d;
  logic                 res_ld, syn_ld, tmo;
  logic                 accept;
  logic [TAG_W-1:0]     tag_q;
  logic [7:0]           timer_q;
  logic [NSYN*GF_W-1:0] kes_syn_q;

  assign accept = bus.in_valid && (state_q == ST_IDLE);

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    res_ld  = 1'b0;
    syn_ld  = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (bus.in_syn == '0) begin
            res_d.lambda = LAMBDA_NOERR;
            res_d.omega  = '0;
            res_d.no_err = 1'b1;
            res_d.fail   = 1'b0;
            res_ld       = 1'b1;
            state_d      = ST_OUT;
          end else begin
            syn_ld  = 1'b1;
            state_d = ST_LAUNCH;
          end
        end
      end
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT: begin
        // A completion on the last watchdog cycle still counts as a success.
        if (kes_done) begin
          res_d.lambda = {kes_lambda2, kes_lambda1, kes_lambda0};
          res_d.omega  = {kes_omega1, kes_omega0};
          res_d.no_err = 1'b0;
          res_d.fail   = 1'b0;
          res_ld       = 1'b1;
          state_d      = ST_OUT;
        end else if (timer_q == TMO_LAST) begin
          res_d   = '0;
          res_d.fail = 1'b1;
          res_ld  = 1'b1;
          tmo     = 1'b1;
          state_d = ST_OUT;
        end
      end
      ST_OUT: if (bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      res_q      <= '0;
      tag_q      <= '0;
      timer_q    <= '0;
      kes_syn_q  <= '0;
      err_sticky <= 1'b0;
    end else begin
      state_q <= state_d;
      if (res_ld) res_q <= res_d;
      if (accept) tag_q <= bus.in_tag;
      // Only non-bypass blocks reload the KES inputs, so they hold otherwise.
      if (syn_ld) kes_syn_q <= bus.in_syn;
      if (state_q == ST_LAUNCH)    timer_q <= '0;
      else if (state_q == ST_WAIT) timer_q <= timer_q + 8'd1;
      if (tmo) err_sticky <= 1'b1;
    end
  end

  assign bus.in_ready   = (state_q == ST_IDLE);
  assign bus.out_valid  = (state_q == ST_OUT);
  assign bus.out_lambda = res_q.lambda;
  assign bus.out_omega  = res_q.omega;
  assign bus.out_no_err = res_q.no_err;
  assign bus.out_fail   = res_q.fail;
  assign bus.out_tag    = tag_q;
  assign kes_ena        = (state_q == ST_LAUNCH);
  assign {kes_syn3, kes_syn2, kes_syn1, kes_syn0} = kes_syn_q;

`ifdef KES_SCHED_STATS_EN
  logic out_hs;
  assign out_hs = bus.out_valid && bus.out_ready;

  rs_kes_sched_stats #(.CNT_W(CNT_W)) u_stats (
    .clk         (clk),
    .rstn        (rstn),
    .hs          (out_hs),
    .no_err      (res_q.no_err),
    .fail        (res_q.fail),
    .stat_blocks (stat_blocks),
    .stat_bypass (stat_bypass),
    .stat_fail   (stat_fail)
  );
`endif
endmodule

// File: tb/tb_rs_kes_sched.sv
// Directed bench for rs_kes_sched: table of blocks with a scripted KES model, plus reset/spurious-event sequences.
module tb_rs_kes_sched;
  logic       clk = 1'b0;
  logic       rstn;
  logic       kes_ena, kes_done, err_sticky;
  logic [7:0] kes_syn0, kes_syn1, kes_syn2, kes_syn3;
  logic [7:0] kes_lambda0, kes_lambda1, kes_lambda2, kes_omega0, kes_omega1;
`ifdef KES_SCHED_STATS_EN
  logic [15:0] stat_blocks, stat_bypass, stat_fail;
  int m_blocks = 0, m_bypass = 0, m_fail = 0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic sticky_model = 1'b0;

  rs_kes_sched_if #(.TAG_W(4)) bus ();

  rs_kes_sched #(.TAG_W(4), .TMO_CYC(8), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn), .bus(bus),
    .kes_ena(kes_ena),
    .kes_syn0(kes_syn0), .kes_syn1(kes_syn1), .kes_syn2(kes_syn2), .kes_syn3(kes_syn3),
    .kes_done(kes_done),
    .kes_lambda0(kes_lambda0), .kes_lambda1(kes_lambda1), .kes_lambda2(kes_lambda2),
    .kes_omega0(kes_omega0), .kes_omega1(kes_omega1),
    .err_sticky(err_sticky)
`ifdef KES_SCHED_STATS_EN
    , .stat_blocks(stat_blocks), .stat_bypass(stat_bypass), .stat_fail(stat_fail)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [31:0] syn;
    logic [3:0]  tag;
    int          dly;      // cycles from launch to kes_done; 0 = never
    logic [23:0] lam;
    logic [15:0] om;
    int          hold;     // cycles out_ready is held low with a result pending
    logic [23:0] exp_lam;
    logic [15:0] exp_om;
    logic        exp_no_err;
    logic        exp_fail;
    int          exp_lat;  // negedges from driving in_valid to out_valid
    int          exp_ena;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int   ena_cnt, launch_at, lat, w;
    logic got, syn_bad, stall_bad;
    w = 0;
    while (!bus.in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk($sformatf("v%0d in_ready_idle", idx), 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_syn   = v.syn;
    bus.in_tag   = v.tag;
    {kes_lambda2, kes_lambda1, kes_lambda0} = v.lam;
    {kes_omega1, kes_omega0} = v.om;
    ena_cnt = 0; launch_at = -1; lat = 0; got = 1'b0; syn_bad = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      kes_done = 1'b0;
      if (kes_ena) begin
        ena_cnt++;
        launch_at = c;
      end
      if (launch_at > 0 && {kes_syn3, kes_syn2, kes_syn1, kes_syn0} !== v.syn) syn_bad = 1'b1;
      if (bus.out_valid) begin
        got = 1'b1;
        lat = c;
      end else if (launch_at > 0 && v.dly > 0 && c == launch_at + v.dly) begin
        kes_done = 1'b1;
      end
    end
    chk($sformatf("v%0d out_valid_seen", idx), 32'(got), 32'd1);
    chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.exp_lat));
    chk($sformatf("v%0d kes_ena_pulses", idx), 32'(ena_cnt), 32'(v.exp_ena));
    if (v.exp_ena > 0) chk($sformatf("v%0d kes_syn_stable", idx), 32'(syn_bad), 32'd0);
    chk($sformatf("v%0d lambda", idx), 32'(bus.out_lambda), 32'(v.exp_lam));
    chk($sformatf("v%0d omega", idx), 32'(bus.out_omega), 32'(v.exp_om));
    chk($sformatf("v%0d tag", idx), 32'(bus.out_tag), 32'(v.tag));
    chk($sformatf("v%0d no_err", idx), 32'(bus.out_no_err), 32'(v.exp_no_err));
    chk($sformatf("v%0d fail", idx), 32'(bus.out_fail), 32'(v.exp_fail));
    chk($sformatf("v%0d in_ready_busy", idx), 32'(bus.in_ready), 32'd0);
    stall_bad = 1'b0;
    for (int h = 0; h < v.hold; h++) begin
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_syn    = 32'h5555_5555;
      bus.in_tag    = 4'h1;
      @(negedge clk);
      if (!bus.out_valid || bus.in_ready || kes_ena ||
          bus.out_lambda !== v.exp_lam || bus.out_omega !== v.exp_om ||
          bus.out_tag !== v.tag || bus.out_no_err !== v.exp_no_err ||
          bus.out_fail !== v.exp_fail) stall_bad = 1'b1;
    end
    if (v.hold > 0) chk($sformatf("v%0d stall_stable", idx), 32'(stall_bad), 32'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    if (v.exp_fail) sticky_model = 1'b1;
`ifdef KES_SCHED_STATS_EN
    m_blocks++;
    if (v.exp_no_err) m_bypass++;
    if (v.exp_fail)   m_fail++;
`endif
    chk($sformatf("v%0d out_valid_drop", idx), 32'(bus.out_valid), 32'd0);
    chk($sformatf("v%0d in_ready_back", idx), 32'(bus.in_ready), 32'd1);
    chk($sformatf("v%0d err_sticky", idx), 32'(err_sticky), 32'(sticky_model));
  endtask

  initial begin
    //            syn            tag  dly lam        om        hold exp_lam     exp_om    ne   f    lat ena
    vecs[0] = '{32'h0000_0000, 4'h3, 0, 24'h000000, 16'h0000, 0, 24'h000001, 16'h0000, 1'b1, 1'b0, 1,  0};
    vecs[1] = '{32'h0A1F_33C4, 4'h5, 3, 24'h005A01, 16'h0077, 0, 24'h005A01, 16'h0077, 1'b0, 1'b0, 5,  1};
    vecs[2] = '{32'h0000_0001, 4'h9, 1, 24'h123456, 16'hABCD, 0, 24'h123456, 16'hABCD, 1'b0, 1'b0, 3,  1};
    vecs[3] = '{32'h8000_0000, 4'hF, 0, 24'hFFFFFF, 16'hFFFF, 0, 24'h000000, 16'h0000, 1'b0, 1'b1, 10, 1};
    vecs[4] = '{32'h00C3_0000, 4'h6, 8, 24'hA1B2C3, 16'hD4E5, 0, 24'hA1B2C3, 16'hD4E5, 1'b0, 1'b0, 10, 1};
    vecs[5] = '{32'h1234_5678, 4'hA, 2, 24'h0F0E0D, 16'h0C0B, 5, 24'h0F0E0D, 16'h0C0B, 1'b0, 1'b0, 4,  1};
    vecs[6] = '{32'h0000_0000, 4'h0, 0, 24'h000000, 16'h0000, 2, 24'h000001, 16'h0000, 1'b1, 1'b0, 1,  0};

    rstn = 1'b0;
    bus.in_valid = 1'b0; bus.in_syn = '0; bus.in_tag = '0; bus.out_ready = 1'b0;
    kes_done = 1'b0;
    {kes_lambda2, kes_lambda1, kes_lambda0, kes_omega1, kes_omega0} = '0;
    repeat (2) @(negedge clk);
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst out_lambda", 32'(bus.out_lambda), 32'd0);
    chk("rst kes_ena", 32'(kes_ena), 32'd0);
    chk("rst err_sticky", 32'(err_sticky), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst in_ready", 32'(bus.in_ready), 32'd1);
    chk("post_rst out_tag", 32'(bus.out_tag), 32'd0);

    // kes_done outside WAIT must not produce a result.
    kes_done = 1'b1;
    {kes_lambda2, kes_lambda1, kes_lambda0} = 24'hEEEEEE;
    @(negedge clk);
    kes_done = 1'b0;
    chk("spurious_done out_valid", 32'(bus.out_valid), 32'd0);
    chk("spurious_done in_ready", 32'(bus.in_ready), 32'd1);
    chk("spurious_done kes_ena", 32'(kes_ena), 32'd0);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Reset in the middle of a KES wait.
    bus.in_valid = 1'b1; bus.in_syn = 32'h0000_0011; bus.in_tag = 4'h7;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("midwait sticky_before", 32'(err_sticky), 32'd1);
    chk("midwait in_ready_before", 32'(bus.in_ready), 32'd0);
    rstn = 1'b0;
    #1;
    chk("midwait rst in_ready", 32'(bus.in_ready), 32'd1);
    chk("midwait rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("midwait rst err_sticky", 32'(err_sticky), 32'd0);
    chk("midwait rst kes_syn0", 32'(kes_syn0), 32'd0);
    chk("midwait rst out_fail", 32'(bus.out_fail), 32'd0);
    sticky_model = 1'b0;
`ifdef KES_SCHED_STATS_EN
    chk("midwait rst stat_blocks", 32'(stat_blocks), 32'd0);
    chk("midwait rst stat_fail", 32'(stat_fail), 32'd0);
    m_blocks = 0; m_bypass = 0; m_fail = 0;
`endif
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("midwait release in_ready", 32'(bus.in_ready), 32'd1);
    chk("midwait release out_valid", 32'(bus.out_valid), 32'd0);
    run_vec(7, vecs[1]);
    run_vec(8, vecs[0]);

`ifdef KES_SCHED_STATS_EN
    chk("stat_blocks", 32'(stat_blocks), 32'(m_blocks));
    chk("stat_bypass", 32'(stat_bypass), 32'(m_bypass));
    chk("stat_fail", 32'(stat_fail), 32'(m_fail));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
